// File: rtl/even_operand_fwd.sv
// Even-pipe register-fetch/forward stage: scoreboard, operand forwarding, RAW stall.
// Define EVEN_FWD_CHECK_EN to build the sticky forwarding-address check (fwd_err).
module even_operand_fwd #(
  parameter int unsigned NREG   = 128,
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned MAXAGE = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(NREG)-1:0]        in_ra_addr,
  input  logic [$clog2(NREG)-1:0]        in_rb_addr,
  input  logic [$clog2(NREG)-1:0]        in_rc_addr,
  input  logic [2:0]                     in_src_used,
  input  logic [WIDTH-1:0]               in_ra_rf,
  input  logic [WIDTH-1:0]               in_rb_rf,
  input  logic [WIDTH-1:0]               in_rc_rf,
  input  logic [$clog2(NREG)-1:0]        in_rt_addr,
  input  logic                           in_reg_write,
  input  logic [2:0]                     in_lat,
  input  logic [15:0]                    in_ctl,
  input  logic                           branch_taken,
  input  logic [6:0][0:WIDTH-1]          fw_wb,
  input  logic [6:0][0:$clog2(NREG)-1]   fw_addr_wb,
  input  logic [6:0]                     fw_write_wb,
  input  logic [WIDTH-1:0]               rt_wb,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_ra,
  output logic [WIDTH-1:0]               out_rb,
  output logic [WIDTH-1:0]               out_rc,
  output logic [$clog2(NREG)-1:0]        out_rt_addr,
  output logic                           out_reg_write,
  output logic [15:0]                    out_ctl,
  output logic [15:0]                    stall_cnt,
  output logic                           fwd_err
);
  localparam int unsigned AW = $clog2(NREG);
  localparam logic [2:0] AGE_LAST = 3'(MAXAGE);

  logic [2:0] sb_age [NREG];
  logic [2:0] sb_lat [NREG];

  logic [AW-1:0]    src_addr [3];
  logic [WIDTH-1:0] src_rf   [3];
  logic [WIDTH-1:0] src_val  [3];
  logic [2:0]       src_a    [3];
  logic [2:0]       src_l    [3];
  logic [2:0]       src_used;
  logic [2:0]       src_haz;
  logic [2:0]       src_fwd;
  logic [2:0]       src_rt;
  logic             stall;
  logic             accept;

  assign src_addr[0] = in_ra_addr;
  assign src_addr[1] = in_rb_addr;
  assign src_addr[2] = in_rc_addr;
  assign src_rf[0]   = in_ra_rf;
  assign src_rf[1]   = in_rb_rf;
  assign src_rf[2]   = in_rc_rf;
  // in_src_used is ordered {ra,rb,rc}; index 0 of the source arrays is ra
  assign src_used    = {in_src_used[0], in_src_used[1], in_src_used[2]};

  always_comb begin
    src_haz = '0;
    src_fwd = '0;
    src_rt  = '0;
    for (int unsigned s = 0; s < 3; s++) begin
      src_a[s]   = sb_age[src_addr[s]];
      src_l[s]   = sb_lat[src_addr[s]];
      src_val[s] = src_rf[s];
      if (src_a[s] == AGE_LAST) begin
        src_val[s] = rt_wb;
        src_rt[s]  = 1'b1;
      end else if (src_a[s] != '0) begin
        if (src_a[s] >= src_l[s]) begin
          src_val[s] = fw_wb[src_a[s]];
          src_fwd[s] = 1'b1;
        end else begin
          src_haz[s] = src_used[s];
        end
      end
    end
  end

  assign stall    = in_valid & (|src_haz);
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall & ~branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        sb_age[r] <= '0;
        sb_lat[r] <= '0;
      end
      out_valid     <= 1'b0;
      out_ra        <= '0;
      out_rb        <= '0;
      out_rc        <= '0;
      out_rt_addr   <= '0;
      out_reg_write <= 1'b0;
      out_ctl       <= '0;
      stall_cnt     <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (sb_age[r] == AGE_LAST)
          sb_age[r] <= '0;
        else if (sb_age[r] != '0)
          sb_age[r] <= sb_age[r] + 3'd1;
      end
      // later assignment overrides the ageing above, so a new write beats expiry
      if (accept && in_reg_write) begin
        sb_age[in_rt_addr] <= 3'd1;
        sb_lat[in_rt_addr] <= in_lat;
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
      out_valid <= accept;
      if (accept) begin
        out_ra        <= src_val[0];
        out_rb        <= src_val[1];
        out_rc        <= src_val[2];
        out_rt_addr   <= in_rt_addr;
        out_reg_write <= in_reg_write;
        out_ctl       <= in_ctl;
      end
    end
  end

`ifdef EVEN_FWD_CHECK_EN
  // sh_addr[k]/sh_vld[k] hold the destination issued k cycles ago
  logic [AW-1:0]   sh_addr [1:MAXAGE];
  logic [MAXAGE:1] sh_vld;
  logic            chk_bad;

  always_comb begin
    chk_bad = 1'b0;
    for (int unsigned s = 0; s < 3; s++) begin
      if (src_used[s]) begin
        if (src_fwd[s] && (!fw_write_wb[src_a[s]] || fw_addr_wb[src_a[s]] != src_addr[s]))
          chk_bad = 1'b1;
        if (src_rt[s] && (!sh_vld[MAXAGE] || sh_addr[MAXAGE] != src_addr[s]))
          chk_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= MAXAGE; k++)
        sh_addr[k] <= '0;
      sh_vld  <= '0;
      fwd_err <= 1'b0;
    end else begin
      for (int unsigned k = MAXAGE; k > 1; k--)
        sh_addr[k] <= sh_addr[k-1];
      sh_addr[1] <= in_rt_addr;
      sh_vld     <= {sh_vld[MAXAGE-1:1], accept & in_reg_write};
      if (accept && chk_bad)
        fwd_err <= 1'b1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^{fw_addr_wb, fw_write_wb, src_fwd, src_rt};
  assign fwd_err    = 1'b0;
`endif

endmodule
